// File: rtl/gc_arbiter_pkg.sv
// Shared sizing for the global-counter arbiter.
// Core count, counter width and index-width helper.
package gc_arbiter_pkg;

  localparam int N_CORE   = 4;
  localparam int GC_WIDTH = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gc_arbiter_rr_select.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Ports: req, ptr in; grant (one-hot), idx, any out. Combinational.
module rr_select
  import gc_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [idx_w(N)-1:0] idx,
  output logic                any
);

  localparam int IW = idx_w(N);

  logic [2*N-1:0] dbl;

  // Doubling the vector turns the wrap into a straight scan
  always_comb begin
    dbl   = {req, req};
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && dbl[int'(ptr) + k]) begin
        any = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/gc_arbiter.sv
// Owns the global counter; grants one core per cycle round-robin.
// Ports: clk, reset, req_valid/req_ready, gc, set_valid/set_value,
// overflow, grant_count.
module gc_arbiter
  import gc_arbiter_pkg::*;
#(
  parameter int N_CORE   = gc_arbiter_pkg::N_CORE,
  parameter int GC_WIDTH = gc_arbiter_pkg::GC_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CORE-1:0]   req_valid,
  output logic [N_CORE-1:0]   req_ready,
  output logic [GC_WIDTH-1:0] gc,
  input  logic                set_valid,
  input  logic [GC_WIDTH-1:0] set_value,
  output logic                overflow,
  output logic [GC_WIDTH-1:0] grant_count
);

  localparam int IW = idx_w(N_CORE);

  logic [IW-1:0]     ptr;
  logic [IW-1:0]     ptr_nxt;
  logic [IW-1:0]     sel_idx;
  logic [N_CORE-1:0] sel_grant;
  logic              sel_any;
  logic              grant;

  rr_select #(.N(N_CORE)) u_sel (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // A load wins over any request; reset voids the handshake at once
  assign grant     = sel_any && !set_valid && !reset;
  assign req_ready = grant ? sel_grant : '0;

  always_comb begin
    ptr_nxt = sel_idx + 1'b1;
    if (sel_idx == IW'(N_CORE - 1))
      ptr_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gc          <= '0;
      ptr         <= '0;
      overflow    <= 1'b0;
      grant_count <= '0;
    end else if (set_valid) begin
      gc          <= set_value;
      overflow    <= 1'b0;
      grant_count <= '0;
    end else if (grant) begin
      gc          <= gc + 1'b1;
      ptr         <= ptr_nxt;
      grant_count <= grant_count + 1'b1;
      if (&gc)
        overflow <= 1'b1;
    end
  end

endmodule

// File: doc/gc_arbiter.md
Name: gc_arbiter

Overview:
- Owns the global counter (gc) shared by all cores.
- Arbitrates the per-core gc_req handshakes raised by each core's `next` unit, round-robin, at most one grant per cycle.
- Broadcasts the pre-increment value to every core and post-increments on each grant.
- Gives the master core a configuration port to load gc before a parallel region.

Parameters:
- N_CORE, 4, number of requesting cores (≥2).
- GC_WIDTH, 16, width of the counter; must equal the codebase-wide GC_WIDTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_CORE  per-core gc_req.valid.
- req_ready  output  N_CORE  per-core gc_req.ready (grant); one-hot or zero.
- gc  output  GC_WIDTH  current counter value, broadcast to all cores.
- set_valid  input  1  master core loads gc this cycle.
- set_value  input  GC_WIDTH  value to load.
- overflow  output  1  sticky; gc wrapped since last set/reset.
- grant_count  output  GC_WIDTH  grants since last set/reset (debug/perf), wrapping.

Behaviour:
- Reset (asynchronous, immediate):
  - gc=0, rr pointer=0, overflow=0, grant_count=0.
  - req_ready=0 while reset is high.
- Handshake follows the req_if rule: valid never depends on ready; ready may depend on valid combinationally.
  - Transfer occurs when req_valid[i] && req_ready[i] in the same cycle.
  - The requester samples gc in that cycle; no added latency.
- Grant selection (combinational):
  - Search cores starting at rr pointer p in order p, p+1, …, N_CORE-1, 0, …, p-1.
  - The first core with req_valid set gets req_ready=1; all others get 0.
- On a grant to core i:
  - next cycle gc = gc+1 mod 2^GC_WIDTH.
  - p = (i+1) mod N_CORE.
  - grant_count += 1.
- With no grant, p and gc hold.
- set_valid has priority:
  - In a cycle with set_valid=1, req_ready is all zeros (no grant).
  - Next cycle: gc=set_value, overflow=0, grant_count=0, p unchanged.
- Wrap-around: a grant while gc=2^GC_WIDTH-1 makes gc=0 and sets overflow=1. overflow stays set until set_valid or reset.
- Requesters may drop req_valid without a grant (failure flush in the requester); the arbiter keeps no per-request state, so dropping is always legal.
- gc is a pure register output; it never changes combinationally within a cycle.
- Reset asserted mid-stream: state clears immediately. Any handshake in that cycle is void; requesters see ready=0.

Decomposition:
- common.vh: N_CORE, GC_WIDTH, and the req_if interface (already shared).
- Sub-module rr_select (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational, built with a doubled-vector priority search.
- gc_arbiter holds all registers: gc, p, overflow, grant_count.

Test Plan:
- Reset then idle: req_valid=0000 for 5 cycles -> gc=0, req_ready=0000, overflow=0, grant_count=0 throughout.
- All four cores request continuously from p=0, gc=0 -> grants to cores 0,1,2,3,0,… one per cycle. The granted core sees gc=0,1,2,3,4. grant_count=5 after 5 cycles.
- set_valid=1, set_value=0x0100 while req_valid=1111 -> that cycle req_ready=0000. Next cycle gc=0x0100, grant_count=0. Following grant goes to the core after the last granted one and sees 0x0100.
- Wrap: set gc=0xFFFE; core 2 requests 3 consecutive cycles -> sees 0xFFFE, 0xFFFF, 0x0000. overflow rises the cycle after the 0xFFFF grant and stays 1 until the next set_valid.
- Fairness with pointer p=3: req_valid=0101 -> core 0 granted first (p becomes 1), then core 2 (p becomes 3), then core 0. Neither core waits more than one grant.
- Async reset pulse mid-cycle during a grant to core 1 at gc=7 -> immediately gc=0, req_ready=0000, p=0, overflow=0. The aborted grant does not increment gc after reset release.
